// File: rtl/wb_pkg.sv
// Shared types and widths for the register write-back stage.
//
// Contents:
//   XLEN       - datapath width
//   REG_ADDR_W - register address width
//   NUM_REGS   - number of architectural registers (width of the pending mask)
//   wb_req_t   - one register write request {rd, data}
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_md_fifo.sv
// Result FIFO for the multi-cycle MUL/DIV unit.
//
// Holds results until the write-back arbiter gets a free write slot. The
// pending mask tells the hazard unit which destinations still have a result
// parked here.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (discards entries)
//   push_i       - enqueue push_req_i (ignored while full)
//   push_req_i   - result to enqueue
//   pop_i        - drop the head entry (ignored while empty)
//   head_o       - oldest entry, valid while not_empty_o
//   not_empty_o  - at least one entry held
//   ready_o      - space available, from the registered count only
//   pending_o    - one-hot OR of rd over all held entries
module wb_md_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  wb_req_t             push_req_i,
  input  logic                pop_i,
  output wb_req_t             head_o,
  output logic                not_empty_o,
  output logic                ready_o,
  output logic [NUM_REGS-1:0] pending_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign ready_o     = (count_q < CNT_W'(DEPTH));
  assign not_empty_o = (count_q != '0);
  assign head_o      = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign push_ok = push_i && ready_o;
  assign pop_ok  = pop_i && not_empty_o;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone decides
  // which slots hold live data, and leaving the array out of reset keeps it
  // mappable onto plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_req_i;
  end

  // Walk the live window [rd_ptr, rd_ptr + count) and OR in each destination.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q)
        pending_o[mem_q[rd_ptr_q + PTR_W'(i)].rd] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-back stage: sole driver of the register file write port.
//
// Merges the in-order MEM/WB result stream with out-of-order MUL/DIV results.
// MUL/DIV results wait in wb_md_fifo; the main pipe has priority, but a FIFO
// head that has waited STARVE_LIMIT cycles raises WB_STALL for one cycle and
// takes the write slot. All write-port outputs are registered.
//
// Optional feature (macro WB_FWD_EN): same-cycle forwarding of the value
// being written to two read ports (RS1_/RS2_ADDR -> RSn_FWD, FWD_DATAn).
//
// Ports:
//   CLK, RESET                     - clock, asynchronous active-low reset
//   MEM_VALID/WEN/RD/DATA          - main-pipe result
//   WB_STALL                       - main pipe must hold MEM/WB this cycle
//   MD_VALID/READY/RD/DATA         - MUL/DIV result handshake
//   MD_PENDING                     - destinations with a result in the FIFO
//   WB_WRITE, WB_ADDR, WB_DATA     - register file WRITE, INADDRESS, IN
module reg_writeback_unit
  import wb_pkg::*;
#(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MEM_VALID,
  input  logic                  MEM_WEN,
  input  logic [REG_ADDR_W-1:0] MEM_RD,
  input  logic [XLEN-1:0]       MEM_DATA,
  output logic                  WB_STALL,
  input  logic                  MD_VALID,
  output logic                  MD_READY,
  input  logic [REG_ADDR_W-1:0] MD_RD,
  input  logic [XLEN-1:0]       MD_DATA,
  output logic [NUM_REGS-1:0]   MD_PENDING,
  output logic                  WB_WRITE,
  output logic [REG_ADDR_W-1:0] WB_ADDR,
  output logic [XLEN-1:0]       WB_DATA
`ifdef WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] RS1_ADDR,
  input  logic [REG_ADDR_W-1:0] RS2_ADDR,
  output logic                  RS1_FWD,
  output logic                  RS2_FWD,
  output logic [XLEN-1:0]       FWD_DATA1,
  output logic [XLEN-1:0]       FWD_DATA2
`endif
);

  localparam int                AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic                  main_live;
  logic                  md_push, md_pop;
  logic                  md_not_empty;
  wb_req_t               md_head;

  logic [AGE_W-1:0]      age_q, age_d;
  logic                  stall_q, stall_d;
  logic                  wb_write_q, wb_write_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;

  // Writes to x0 are dropped at the door: main results are consumed silently
  // and MUL/DIV results are accepted but never enqueued.
  assign main_live = MEM_VALID && MEM_WEN && (MEM_RD != '0);
  assign md_push   = MD_VALID && MD_READY && (MD_RD != '0);

  wb_md_fifo #(
    .DEPTH (MD_DEPTH)
  ) u_md_fifo (
    .clk         (CLK),
    .rst_n       (RESET),
    .push_i      (md_push),
    .push_req_i  ('{rd: MD_RD, data: MD_DATA}),
    .pop_i       (md_pop),
    .head_o      (md_head),
    .not_empty_o (md_not_empty),
    .ready_o     (MD_READY),
    .pending_o   (MD_PENDING)
  );

  // Arbitration: starved FIFO head, then main pipe, then idle-slot drain.
  // WB_ADDR/WB_DATA hold their last value when no write is issued.
  always_comb begin
    md_pop     = 1'b0;
    wb_write_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if ((stall_q || !main_live) && md_not_empty) begin
      md_pop     = 1'b1;
      wb_write_d = 1'b1;
      wb_addr_d  = md_head.rd;
      wb_data_d  = md_head.data;
    end else if (!stall_q && main_live) begin
      wb_write_d = 1'b1;
      wb_addr_d  = MEM_RD;
      wb_data_d  = MEM_DATA;
    end
  end

  // Age of the FIFO head in cycles spent waiting; the stall flop is simply
  // "age has hit the limit", and the stall cycle pops the head, so each
  // starvation event produces exactly one stall cycle.
  always_comb begin
    if (!md_not_empty || md_pop) age_d = '0;
    else if (age_q != AGE_MAX)   age_d = age_q + AGE_W'(1);
    else                         age_d = age_q;
    stall_d = (age_d == AGE_MAX);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      age_q      <= '0;
      stall_q    <= 1'b0;
      wb_write_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      age_q      <= age_d;
      stall_q    <= stall_d;
      wb_write_q <= wb_write_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign WB_STALL = stall_q;
  assign WB_WRITE = wb_write_q;
  assign WB_ADDR  = wb_addr_q;
  assign WB_DATA  = wb_data_q;

`ifdef WB_FWD_EN
  // Combinational bypass for a read of the register being written this cycle.
  assign RS1_FWD   = wb_write_q && (wb_addr_q == RS1_ADDR) && (RS1_ADDR != '0);
  assign RS2_FWD   = wb_write_q && (wb_addr_q == RS2_ADDR) && (RS2_ADDR != '0);
  assign FWD_DATA1 = wb_data_q;
  assign FWD_DATA2 = wb_data_q;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_reg_writeback_unit;
  import wb_pkg::*;

  localparam int MD_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic                  CLK = 1'b0;
  logic                  RESET = 1'b1;
  logic                  MEM_VALID, MEM_WEN, MD_VALID;
  logic [REG_ADDR_W-1:0] MEM_RD, MD_RD;
  logic [XLEN-1:0]       MEM_DATA, MD_DATA;
  logic                  WB_STALL, MD_READY, WB_WRITE;
  logic [NUM_REGS-1:0]   MD_PENDING;
  logic [REG_ADDR_W-1:0] WB_ADDR;
  logic [XLEN-1:0]       WB_DATA;
  logic [REG_ADDR_W-1:0] RS1_ADDR, RS2_ADDR;
`ifdef WB_FWD_EN
  logic                  RS1_FWD, RS2_FWD;
  logic [XLEN-1:0]       FWD_DATA1, FWD_DATA2;
`endif

  always #5 CLK = ~CLK;

  reg_writeback_unit #(
    .MD_DEPTH     (MD_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MEM_VALID  (MEM_VALID),
    .MEM_WEN    (MEM_WEN),
    .MEM_RD     (MEM_RD),
    .MEM_DATA   (MEM_DATA),
    .WB_STALL   (WB_STALL),
    .MD_VALID   (MD_VALID),
    .MD_READY   (MD_READY),
    .MD_RD      (MD_RD),
    .MD_DATA    (MD_DATA),
    .MD_PENDING (MD_PENDING),
    .WB_WRITE   (WB_WRITE),
    .WB_ADDR    (WB_ADDR),
    .WB_DATA    (WB_DATA)
`ifdef WB_FWD_EN
    ,
    .RS1_ADDR   (RS1_ADDR),
    .RS2_ADDR   (RS2_ADDR),
    .RS1_FWD    (RS1_FWD),
    .RS2_FWD    (RS2_FWD),
    .FWD_DATA1  (FWD_DATA1),
    .FWD_DATA2  (FWD_DATA2)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: FIFO contents, head wait time, and the write due on the
  // register port for the current cycle.
  wb_req_t               m_q[$];
  int                    m_age;
  bit                    m_write;
  logic [REG_ADDR_W-1:0] m_addr;
  logic [XLEN-1:0]       m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [NUM_REGS-1:0] model_pending();
    logic [NUM_REGS-1:0] p = '0;
    foreach (m_q[i]) p[m_q[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_age   = 0;
    m_write = 0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit      starved   = (m_age == STARVE_LIMIT);
    bit      live      = MEM_VALID && MEM_WEN && (MEM_RD != 0);
    bit      has_room  = (m_q.size() < MD_DEPTH);
    bit      was_empty = (m_q.size() == 0);
    bit      popped    = 0;
    wb_req_t h;
    m_write = 0;
    if ((starved || !live) && !was_empty) begin
      h = m_q.pop_front();
      popped  = 1;
      m_write = 1;
      m_addr  = h.rd;
      m_data  = h.data;
    end else if (live) begin
      m_write = 1;
      m_addr  = MEM_RD;
      m_data  = MEM_DATA;
    end
    if (popped || was_empty) m_age = 0;
    else if (m_age < STARVE_LIMIT) m_age++;
    if (MD_VALID && has_room && MD_RD != 0) begin
      h.rd   = MD_RD;
      h.data = MD_DATA;
      m_q.push_back(h);
    end
  endtask

  task automatic check_outputs();
    check("wb_write", WB_WRITE, m_write);
    if (m_write) begin
      check("wb_addr", WB_ADDR, m_addr);
      check("wb_data", WB_DATA, m_data);
    end
    check("wb_stall", WB_STALL, m_age == STARVE_LIMIT);
    check("md_ready", MD_READY, m_q.size() < MD_DEPTH);
    check("md_pending", MD_PENDING, model_pending());
`ifdef WB_FWD_EN
    check("rs1_fwd", RS1_FWD, m_write && m_addr == RS1_ADDR && RS1_ADDR != 0);
    check("rs2_fwd", RS2_FWD, m_write && m_addr == RS2_ADDR && RS2_ADDR != 0);
    if (m_write) begin
      check("fwd_data1", FWD_DATA1, m_data);
      check("fwd_data2", FWD_DATA2, m_data);
    end
`endif
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic drive_idle();
    MEM_VALID = 0; MEM_WEN = 0; MEM_RD = '0; MEM_DATA = '0;
    MD_VALID  = 0; MD_RD   = '0; MD_DATA = '0;
    RS1_ADDR  = '0; RS2_ADDR = '0;
  endtask

  task automatic drive_main(input logic [REG_ADDR_W-1:0] rd, input logic [XLEN-1:0] data);
    MEM_VALID = 1; MEM_WEN = 1; MEM_RD = rd; MEM_DATA = data;
  endtask

  task automatic drive_md(input logic valid, input logic [REG_ADDR_W-1:0] rd,
                          input logic [XLEN-1:0] data);
    MD_VALID = valid; MD_RD = rd; MD_DATA = data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_write"}, WB_WRITE, 1'b0);
    check({tag, "_addr"}, WB_ADDR, 5'd0);
    check({tag, "_data"}, WB_DATA, 32'd0);
    check({tag, "_stall"}, WB_STALL, 1'b0);
    check({tag, "_pending"}, MD_PENDING, 32'd0);
  endtask

  initial begin
    drive_idle();
    model_reset();

    // Power-on reset.
    #1 RESET = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge CLK) RESET = 1'b1;
    #1 check("por_ready", MD_READY, 1'b1);
    @(negedge CLK);

    // Main-pipe write: one cycle pulse, then quiet.
    drive_main(5'd2, 32'd95);
    cycle();
    check("main_write", WB_WRITE, 1'b1);
    check("main_addr", WB_ADDR, 5'd2);
    check("main_data", WB_DATA, 32'd95);
    drive_idle();
    cycle();
    check("main_pulse_end", WB_WRITE, 1'b0);

    // x0 suppression on both sources.
    drive_main(5'd0, 32'hDEAD);
    drive_md(1'b1, 5'd0, 32'hBEEF);
    cycle();
    check("x0_no_write", WB_WRITE, 1'b0);
    check("x0_pending", MD_PENDING, 32'd0);
    check("x0_ready", MD_READY, 1'b1);
    drive_idle();
    cycle();
    check("x0_no_late_write", WB_WRITE, 1'b0);

    // FIFO full and starvation while the main pipe writes every cycle.
    drive_main(5'd1, 32'h100);
    drive_md(1'b1, 5'd7, 32'hA);
    cycle();
    drive_main(5'd1, 32'h101);
    drive_md(1'b1, 5'd8, 32'hB);
    cycle();
    check("full_ready", MD_READY, 1'b0);
    check("full_pend7", MD_PENDING[7], 1'b1);
    check("full_pend8", MD_PENDING[8], 1'b1);
    drive_md(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("pre_starve_stall", WB_STALL, 1'b0);
      drive_main(5'd1, 32'h102 + i);
      cycle();
    end
    check("starve_stall", WB_STALL, 1'b1);
    cycle();  // upstream holds the main request during the stall
    check("starve_write", WB_WRITE, 1'b1);
    check("starve_addr", WB_ADDR, 5'd7);
    check("starve_data", WB_DATA, 32'hA);
    check("starve_one_cycle", WB_STALL, 1'b0);
    check("starve_pending", MD_PENDING, 32'd1 << 8);

    // Idle drain of the remaining entry, then of a fresh one.
    drive_idle();
    cycle();
    check("drain8_addr", WB_ADDR, 5'd8);
    check("drain8_data", WB_DATA, 32'hB);
    drive_md(1'b1, 5'd3, 32'h33);
    cycle();
    check("push3_pending", MD_PENDING, 32'd1 << 3);
    drive_idle();
    cycle();
    check("drain3_write", WB_WRITE, 1'b1);
    check("drain3_addr", WB_ADDR, 5'd3);
    check("drain3_data", WB_DATA, 32'h33);
    check("drain3_pending", MD_PENDING, 32'd0);

`ifdef WB_FWD_EN
    // Same-cycle forwarding of the value being written.
    drive_main(5'd4, 32'h44);
    cycle();
    RS1_ADDR = 5'd4; RS2_ADDR = 5'd0;
    #1;
    check("fwd_rs1", RS1_FWD, 1'b1);
    check("fwd_data1_44", FWD_DATA1, 32'h44);
    check("fwd_rs2_x0", RS2_FWD, 1'b0);
    RS2_ADDR = 5'd4;
    #1 check("fwd_rs2", RS2_FWD, 1'b1);
    @(negedge CLK);
    check_outputs();
    drive_idle();
`endif

    // Reset in the middle of operation discards parked entries.
    drive_main(5'd1, 32'h200);
    drive_md(1'b1, 5'd5, 32'h11);
    cycle();
    drive_md(1'b1, 5'd6, 32'h22);
    cycle();
    check("rst_pending_before", MD_PENDING, (32'd1 << 5) | (32'd1 << 6));
    RESET = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    drive_idle();
    @(negedge CLK) RESET = 1'b1;
    #1 check("midrst_ready", MD_READY, 1'b1);
    @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("midrst_no_write", WB_WRITE, 1'b0);
    end

    // Randomized traffic; alternate busy and quiet main-pipe phases so the
    // FIFO both starves and drains. Upstream holds its request on a stall.
    for (int i = 0; i < 3000; i++) begin
      bit busy = ((i / 150) % 2) == 0;
      if (!WB_STALL) begin
        MEM_VALID = busy ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
        MEM_WEN   = ($urandom_range(0, 5) != 0);
        MEM_RD    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        MEM_DATA  = $urandom;
      end
      MD_VALID = ($urandom_range(0, 2) == 0);
      MD_RD    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      MD_DATA  = $urandom;
      RS1_ADDR = 5'($urandom_range(0, 7));
      RS2_ADDR = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback_unit.md
# reg_writeback_unit

Write-back stage for the RV32IM pipeline: sole driver of the register file write port (`IN`, `INADDRESS`, `WRITE`). It merges the in-order result stream from the MEM/WB boundary with out-of-order results from the multi-cycle MUL/DIV unit. MUL/DIV results are buffered in a small FIFO and arbitrated against the main pipe with anti-starvation. All write-port outputs are registered, so the register file sees stable values for a full cycle before its write edge.

## Interface
- `XLEN`, 32, data width
- `REG_ADDR_W`, 5, register address width
- `MD_DEPTH`, 2, MUL/DIV result FIFO depth (power of two, ≥2)
- `STARVE_LIMIT`, 4, cycles a FIFO head may wait before forcing the main pipe to stall
- `CLK`  in  1  clock; all state updates on rising edge
- `RESET`  in  1  asynchronous, active-low reset
- `MEM_VALID`  in  1  main-pipe result present this cycle
- `MEM_WEN`  in  1  main-pipe instruction writes rd
- `MEM_RD`  in  REG_ADDR_W  main-pipe destination
- `MEM_DATA`  in  XLEN  main-pipe result
- `WB_STALL`  out  1  main pipe must hold its MEM/WB contents this cycle
- `MD_VALID`  in  1  MUL/DIV result offered
- `MD_READY`  out  1  FIFO can accept; transfer when `MD_VALID`&&`MD_READY` at rising edge
- `MD_RD`  in  REG_ADDR_W  MUL/DIV destination
- `MD_DATA`  in  XLEN  MUL/DIV result
- `MD_PENDING`  out  2^REG_ADDR_W  one-hot OR of rd of every FIFO entry, for the hazard unit
- `WB_WRITE`  out  1  to register file `WRITE`
- `WB_ADDR`  out  REG_ADDR_W  to register file `INADDRESS`
- `WB_DATA`  out  XLEN  to register file `IN`

## Operation
- Main request is live when `MEM_VALID && MEM_WEN && MEM_RD != 0`. If `MEM_VALID` is set but the request is not live, the main-pipe result is consumed without a write.
- MUL/DIV transfers with `MD_RD == 0` are accepted, not enqueued, and set no `MD_PENDING` bit.
- `MD_READY` = FIFO count < `MD_DEPTH`, computed from the registered count. There is no push-through when full, even if a pop occurs the same cycle.
- Arbitration each cycle, in priority order:
  1. If `WB_STALL` is asserted: pop the FIFO head. The main request is ignored, and upstream holds it.
  2. Else if the main request is live: write the main request. The FIFO head waits.
  3. Else if the FIFO is non-empty: pop and write the head.
  4. Else: no write.
- Age counter: increments each cycle the FIFO is non-empty and the head is not popped. It clears on pop or when the FIFO is empty, and saturates at `STARVE_LIMIT`.
- `WB_STALL` = (age == `STARVE_LIMIT`), registered.
- Simultaneous push and pop: count is unchanged, and the pointers advance independently. Wrap-around uses modulo-`MD_DEPTH` pointers.
- `MD_PENDING` is recomputed from the valid FIFO entries after every edge. Duplicate rds are allowed in the FIFO, and the bit stays set until the last matching entry pops.
- No WAW reordering checks: the hazard unit must stall issue on `MD_PENDING` hits.

## Timing
- Reset (`RESET`=0, asynchronous): `WB_WRITE`=0, `WB_ADDR`=0, `WB_DATA`=0, `WB_STALL`=0, FIFO empty, `MD_READY`=1 once released, `MD_PENDING`=0, age=0. Any in-flight entries are discarded.
- Main pipe latency: a request live before edge N is driven on `WB_*` after edge N and written into the register file at edge N+1.
- MUL/DIV latency: pushed at edge N. It is eligible for arbitration in the cycle after N, so earliest `WB_WRITE` is after edge N+1.
- `WB_WRITE` is a single-cycle pulse per write. Back-to-back writes on consecutive cycles are allowed.
- `WB_STALL` lasts exactly one cycle per starvation event.

## Configuration
- `WB_FWD_EN` defined: adds inputs `RS1_ADDR`, `RS2_ADDR` (REG_ADDR_W) and outputs `RS1_FWD`, `RS2_FWD` (1) and `FWD_DATA1`, `FWD_DATA2` (XLEN).
  - `RSn_FWD` = `WB_WRITE && WB_ADDR == RSn_ADDR && RSn_ADDR != 0`, with `FWD_DATAn` = `WB_DATA`. This path is combinational and covers the same-cycle write/read hazard.
- `WB_FWD_EN` undefined: these ports and the logic do not exist.

## Structure
- Package `wb_pkg`: `XLEN`, `REG_ADDR_W`, and typedef `wb_req_t` {rd, data}.
- One sub-module, `wb_md_fifo`: holds storage, pointers, count, `MD_READY` and `MD_PENDING`. Arbitration, the age counter and the output registers live in the top.

## Test plan
- Reset mid-operation: enqueue rd=5/0x11 and rd=6/0x22, then drop `RESET` → all outputs 0 immediately, `MD_PENDING`=0, no later write of rd 5 or 6.
- Main write: `MEM_VALID`=`MEM_WEN`=1, rd=2, data=95 → `WB_WRITE`=1, `WB_ADDR`=2, `WB_DATA`=95 for one cycle after the edge.
- x0 suppression: main rd=0 with data 0xDEAD, and MD rd=0 → no `WB_WRITE`, `MD_PENDING`=0, `MD_READY` stays 1.
- FIFO full:
  - Push rd=7/0xA and rd=8/0xB while main writes every cycle → `MD_READY`=0, `MD_PENDING` bits 7 and 8 set.
  - After 4 waiting cycles, `WB_STALL`=1 for one cycle and rd=7/0xA is written.
- Idle drain: FIFO holds rd=3/0x33 and main is idle → written the next cycle, and bit 3 clears.
- `WB_FWD_EN`: write rd=4/0x44 with `RS1_ADDR`=4, `RS2_ADDR`=0 → `RS1_FWD`=1, `FWD_DATA1`=0x44, `RS2_FWD`=0.
